// File: rtl/add_share_arbiter.sv
// Round-robin arbiter granting four requesters time-shared access to one external 32-bit adder.
// Define ADD_SHARE_ARB_OVF_EN to register a signed-overflow flag alongside each result.
`timescale 1ns/1ps
module add_share_arbiter #(
    parameter int PRIO_INIT = 0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [3:0]   req_valid,
    input  logic [127:0] req_a,
    input  logic [127:0] req_b,
    output logic [3:0]   req_ready,
    output logic [31:0]  add_a,
    output logic [31:0]  add_b,
    input  logic [31:0]  add_c,
    output logic [3:0]   rsp_valid,
    output logic [31:0]  rsp_data,
    output logic         rsp_ovf,
    input  logic [3:0]   rsp_ready,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [1:0]  gid_q, gid_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] data_q, data_d;
    logic [1:0]  pick;
    logic [1:0]  idx;
    logic        found;

    // Search upward from the pointer so the most recently served requester goes last.
    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        idx   = ptr_q;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gid_d     = gid_q;
        a_d       = a_q;
        b_d       = b_q;
        data_d    = data_q;
        req_ready = 4'b0000;
        rsp_valid = 4'b0000;
        add_a     = 32'd0;
        add_b     = 32'd0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    req_ready = 4'(1) << pick;
                    gid_d     = pick;
                    a_d       = req_a[{pick, 5'd0} +: 32];
                    b_d       = req_b[{pick, 5'd0} +: 32];
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                add_a   = a_q;
                add_b   = b_q;
                data_d  = add_c;
                state_d = RESP;
            end
            RESP: begin
                rsp_valid = 4'(1) << gid_q;
                if (rsp_ready[gid_q]) begin
                    ptr_d   = gid_q + 2'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= 2'(PRIO_INIT);
            gid_q   <= 2'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            data_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            a_q     <= a_d;
            b_q     <= b_d;
            data_q  <= data_d;
        end
    end

`ifdef ADD_SHARE_ARB_OVF_EN
    logic ovf_q, ovf_d;

    // Same-sign operands whose sum flips sign overflowed in two's complement.
    always_comb begin
        ovf_d = ovf_q;
        if (state_q == EXEC) begin
            ovf_d = (a_q[31] == b_q[31]) & (add_c[31] != a_q[31]);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign rsp_ovf = ovf_q;
`else
    assign rsp_ovf = 1'b0;
`endif

    assign rsp_data = data_q;
    assign busy     = (state_q != IDLE);

endmodule
